secded_mem_decoder: RTL and testbench
=====================================

// Module: secded_mem_decoder
// PURPOSE
//  Hardware SECDED (Hamming 16,11) decode engine sitting beside data memory dm1; performs program-2 work without the core.
//  On start it reads NUM_WORDS corrupted 16-bit codewords (little-endian byte pairs) from SRC_BASE.
//  It corrects single errors and flags double errors.
//  It writes {flag[1:0],3'b000,d[11:1]} byte pairs to DST_BASE, then raises done.
// PARAMETERS
//  NUM_WORDS  15  codewords processed per start
//  SRC_BASE   30  byte address of word 0 low byte (high byte at +1)
//  DST_BASE    0  byte address of result 0 low byte (high byte at +1)
//  AW          8  data-memory address width
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-high; clears all state
//  start         in   1   one-cycle request; sampled only in IDLE
//  dm_rdata      in   8   data-memory read data, combinational from dm_addr
//  dm_addr       out  AW  data-memory byte address
//  dm_wdata      out  8   write data
//  dm_wen        out  1   write enable; memory writes on the rising edge while high
//  busy          out  1   high from the cycle after start until done
//  done          out  1   high in DONE state, held until next accepted start
//  n_single      out  4   count of words with a corrected single error, this run
//  n_double      out  4   count of words flagged double-error, this run
// BEHAVIOUR
//  Reset values: state=IDLE, dm_addr=0, dm_wdata=0, dm_wen=0, busy=0, done=0, counters=0, word index i=0.
//  Codeword layout, bit k = Hamming position k:
//   {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}, bits 15..0; p0 is overall even parity.
//  Syndrome s[3:0] = XOR of k over set bits k=1..15; P = ^w[15:0].
//   s==0, P==0: no error. Out = {5'b00000, d}.
//   P==1: single error. Flip bit s, where s==0 means p0 itself. Out = {5'b01000, corrected d}.
//   s!=0, P==0: double error. Out = {5'b10000, d extracted uncorrected}.
//  Data extraction: d[11:5]=w[15:9], d[4:2]=w[7:5], d[1]=w[3].
//  FSM: IDLE -start-> RD_LO -> RD_HI -> DECODE -> WR_LO -> WR_HI -> (i==NUM_WORDS-1 ? DONE : RD_LO with i+1).
//   RD_LO: dm_addr=SRC_BASE+2i; capture low byte.
//   RD_HI: dm_addr=SRC_BASE+2i+1; capture high byte.
//   DECODE: register result word; bump n_single or n_double.
//   WR_LO: dm_addr=DST_BASE+2i, dm_wdata=res[7:0], dm_wen=1.
//   WR_HI: dm_addr=DST_BASE+2i+1, dm_wdata=res[15:8], dm_wen=1.
//   DONE -start-> RD_LO; this clears done, counters and i.
//  dm_wen is 1 only in WR_LO/WR_HI; all outputs are registered or decoded from state only.
//  Latency: start sampled at edge 0 -> word i written at edges 5i+4, 5i+5 -> done=1 after edge 5*NUM_WORDS+1 (76 for default).
//  start while busy: ignored. start held high: accepted once per IDLE/DONE visit.
//  Reset mid-run: immediate return to IDLE, dm_wen=0. Bytes already written stay; no partial-word write is possible after reset.
//  Address arithmetic is modulo 2^AW; SRC/DST overlap is not checked (caller's responsibility).
//  Counters saturate at 15.
// STRUCTURE
//  Package secded_pkg:
//   state_t enum; FLAG_NONE=2'b00, FLAG_SGL=2'b01, FLAG_DBL=2'b10.
//   function extract_data(w) -> [11:1].
//   function secded_encode(d) -> [15:0], shared with the bench and any encoder block.
//  Sub-module secded_syndrome (combinational): in w[15:0]; out s[3:0], P, corrected w, flag[1:0].
//  Top: FSM, index counter, byte capture regs, result reg, error counters.
// TESTING
//  1 Clean words: 15 words from encode(d_i), start -> dst = {00000,d_i}; n_single=0, n_double=0; done at edge 76.
//  2 Single flip at each position k=0..15, d=11'h5A5 -> all outputs 16'h45A5; n_single=15 (16th word in second run).
//  3 Double flip bits 3 and 9 of encode(11'h7FF) -> high byte [7]=1, out {10000, raw d}; n_double=1.
//  4 Assert reset at edge 12 of a run -> dm_wen=0 same cycle, done=0; dst words 0,1 written, word 2 untouched; restart completes correctly.
//  5 start pulsed at edges 3 and 40 of a run -> ignored; exactly one run; done once at edge 76.
//  6 Back-to-back: start in DONE -> done drops next cycle, counters clear, second results overwrite the first.

Source files
------------

// File: rtl/secded_mem_decoder_pkg.sv
// Shared SECDED (16,11) types, flag codes and codeword helpers for the memory decoder
// and any matching encoder.
package secded_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StDecode,
    StWrLo,
    StWrHi,
    StDone
  } state_t;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_SGL  = 2'b01;
  localparam logic [1:0] FLAG_DBL  = 2'b10;

  function automatic logic [11:1] extract_data(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

  function automatic logic [15:0] secded_encode(input logic [11:1] d);
    logic [15:0] w;
    logic [3:0]  s;
    w = {d[11:5], 1'b0, d[4:2], 1'b0, d[1], 3'b000};
    s = '0;
    for (int k = 1; k < 16; k++) begin
      if (w[k]) s = s ^ 4'(k);
    end
    // With parity slots zero, the data-only syndrome is exactly the parity to insert.
    w[1] = s[0];
    w[2] = s[1];
    w[4] = s[2];
    w[8] = s[3];
    w[0] = ^w[15:1];
    return w;
  endfunction

endpackage

// File: rtl/secded_mem_decoder_if.sv
// Host/memory-side bundle of the SECDED memory decoder; slave is the decoder's view.
interface secded_mem_decoder_if #(
  parameter int unsigned AW = 8
) ();
  logic          start;
  logic [7:0]    dm_rdata;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_wdata;
  logic          dm_wen;
  logic          busy;
  logic          done;
  logic [3:0]    n_single;
  logic [3:0]    n_double;

  modport master (
    output start, dm_rdata,
    input  dm_addr, dm_wdata, dm_wen, busy, done, n_single, n_double
  );

  modport slave (
    input  start, dm_rdata,
    output dm_addr, dm_wdata, dm_wen, busy, done, n_single, n_double
  );
endinterface

// File: rtl/secded_mem_decoder_syndrome.sv
// Combinational SECDED (16,11) check: syndrome, overall parity, corrected word and flag.
module secded_syndrome
  import secded_pkg::*;
(
  input  logic [15:0] i_w,
  output logic [3:0]  o_s,
  output logic        o_p,
  output logic [15:0] o_w_corr,
  output logic [1:0]  o_flag
);

  always_comb begin
    o_s = '0;
    for (int k = 1; k < 16; k++) begin
      if (i_w[k]) o_s = o_s ^ 4'(k);
    end
    o_p      = ^i_w;
    o_w_corr = i_w;
    // Odd parity means one flipped bit; syndrome 0 then points at p0 itself.
    if (o_p) o_w_corr[o_s] = ~i_w[o_s];
    if (o_p)             o_flag = FLAG_SGL;
    else if (o_s != '0)  o_flag = FLAG_DBL;
    else                 o_flag = FLAG_NONE;
  end

endmodule

// File: rtl/secded_mem_decoder.sv
// SECDED decode engine beside dm1: reads NUM_WORDS codewords from SRC_BASE, writes
// {flag, 3'b000, data} byte pairs to DST_BASE, counts single/double errors, raises done.
module secded_mem_decoder
  import secded_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned DST_BASE  = 0,
  parameter int unsigned AW        = 8
) (
  input logic                 clk,
  input logic                 reset,
  secded_mem_decoder_if.slave bus
);

  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic          r_wen;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_n_single;
  logic [3:0]    r_n_double;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic [15:0]   r_res;

  logic [15:0] w_cw;
  logic [3:0]  w_s;
  logic        w_p;
  logic [15:0] w_corr;
  logic [1:0]  w_flag;
  logic [15:0] w_res;

  assign w_cw = {r_hi, r_lo};

  secded_syndrome u_syndrome (
    .i_w      (w_cw),
    .o_s      (w_s),
    .o_p      (w_p),
    .o_w_corr (w_corr),
    .o_flag   (w_flag)
  );

  assign w_res = {w_flag, 3'b000, extract_data(w_corr)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wen      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_n_single <= '0;
      r_n_double <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_res      <= '0;
    end else begin
      r_wen <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          // done rises one cycle after entering StDone; a start here overrides it.
          if (r_state == StDone) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
          if (bus.start) begin
            r_state    <= StRdLo;
            r_idx      <= '0;
            r_addr     <= AW'(SRC_BASE);
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_n_single <= '0;
            r_n_double <= '0;
          end
        end
        StRdLo: begin
          r_lo    <= bus.dm_rdata;
          r_addr  <= r_addr + 1'b1;
          r_state <= StRdHi;
        end
        StRdHi: begin
          r_hi    <= bus.dm_rdata;
          r_state <= StDecode;
        end
        StDecode: begin
          r_res   <= w_res;
          r_addr  <= AW'(DST_BASE + 2 * int'(r_idx));
          r_wdata <= w_res[7:0];
          r_wen   <= 1'b1;
          if (w_p && r_n_single != 4'hF) r_n_single <= r_n_single + 4'd1;
          if (!w_p && w_s != '0 && r_n_double != 4'hF) r_n_double <= r_n_double + 4'd1;
          r_state <= StWrLo;
        end
        StWrLo: begin
          r_addr  <= r_addr + 1'b1;
          r_wdata <= r_res[15:8];
          r_wen   <= 1'b1;
          r_state <= StWrHi;
        end
        StWrHi: begin
          if (r_idx == IW'(NUM_WORDS - 1)) begin
            r_state <= StDone;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_addr  <= AW'(SRC_BASE + 2 * (int'(r_idx) + 1));
            r_state <= StRdLo;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.dm_addr  = r_addr;
  assign bus.dm_wdata = r_wdata;
  assign bus.dm_wen   = r_wen;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.n_single = r_n_single;
  assign bus.n_double = r_n_double;

endmodule

// File: tb/tb_secded_mem_decoder.sv
// Directed bench for secded_mem_decoder: byte memory model, clean/single/double runs,
// ignored starts, back-to-back restart and mid-run reset.
module tb_secded_mem_decoder;
  import secded_pkg::*;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_data;
  logic [7:0] mem [256];
  int         wr_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [15:0] exp_w [NW];

  secded_mem_decoder_if #(.AW(8)) bus_if ();

  secded_mem_decoder #(
    .NUM_WORDS (NW),
    .SRC_BASE  (SRC),
    .DST_BASE  (DST),
    .AW        (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.dm_rdata = mem[bus_if.dm_addr];

  always @(posedge clk) begin
    if (bus_if.dm_wen) begin
      mem[bus_if.dm_addr] <= bus_if.dm_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_addr = 8'(a);
    tb_data = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // kind 0: clean words, 1: single flip at bit i, 2: mixed (flip bit 15, double, clean)
  task automatic load_run(input int kind);
    logic [11:1] d;
    logic [15:0] w;
    for (int i = 0; i < NW; i++) begin
      d = 11'(i * 291 + 5);
      w = secded_encode(d);
      exp_w[i] = {5'b00000, d};
      if (kind == 1) begin
        w = secded_encode(11'h5A5) ^ (16'h0001 << i);
        exp_w[i] = 16'h45A5;
      end else if (kind == 2) begin
        if (i == 0) begin
          w = secded_encode(11'h5A5) ^ 16'h8000;
          exp_w[i] = 16'h45A5;
        end else if (i == 1) begin
          w = 16'hFDF7;  // encode(7FF)=FFFF with bits 3 and 9 flipped
          exp_w[i] = 16'h87EE;
        end else begin
          d = 11'(i * 695 + 240);
          w = secded_encode(d);
          exp_w[i] = {5'b00000, d};
        end
      end
      poke(SRC + 2 * i, w[7:0]);
      poke(SRC + 2 * i + 1, w[15:8]);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < NW; i++) begin
      check_eq($sformatf("%s_word%0d", tag, i), {mem[DST + 2 * i + 1], mem[DST + 2 * i]},
               exp_w[i]);
    end
  endtask

  task automatic do_run(input string tag, input bit pulses, input logic [3:0] exp_sgl,
                        input logic [3:0] exp_dbl);
    int base;
    base = wr_cnt;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    check_eq({tag, "_busy_e0"}, 16'(bus_if.busy), 16'd1);
    check_eq({tag, "_done_e0"}, 16'(bus_if.done), 16'd0);
    check_eq({tag, "_nsgl_e0"}, 16'(bus_if.n_single), 16'd0);
    check_eq({tag, "_ndbl_e0"}, 16'(bus_if.n_double), 16'd0);
    for (int e = 1; e <= 76; e++) begin
      @(posedge clk);
      #1;
      bus_if.start = pulses && (e == 2 || e == 39);
      if (e == 75) begin
        check_eq({tag, "_done_e75"}, 16'(bus_if.done), 16'd0);
        check_eq({tag, "_busy_e75"}, 16'(bus_if.busy), 16'd1);
      end
      if (e == 76) begin
        check_eq({tag, "_done_e76"}, 16'(bus_if.done), 16'd1);
        check_eq({tag, "_busy_e76"}, 16'(bus_if.busy), 16'd0);
      end
    end
    bus_if.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_writes"}, 16'(wr_cnt - base), 16'd30);
    check_eq({tag, "_done_hold"}, 16'(bus_if.done), 16'd1);
    check_eq({tag, "_nsgl"}, 16'(bus_if.n_single), 16'(exp_sgl));
    check_eq({tag, "_ndbl"}, 16'(bus_if.n_double), 16'(exp_dbl));
    check_results(tag);
  endtask

  initial begin
    int base;
    reset        = 1'b1;
    tb_we        = 1'b0;
    tb_addr      = '0;
    tb_data      = '0;
    bus_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr",  16'(bus_if.dm_addr), 16'd0);
    check_eq("rst_wdata", 16'(bus_if.dm_wdata), 16'd0);
    check_eq("rst_wen",   16'(bus_if.dm_wen), 16'd0);
    check_eq("rst_busy",  16'(bus_if.busy), 16'd0);
    check_eq("rst_done",  16'(bus_if.done), 16'd0);
    check_eq("rst_nsgl",  16'(bus_if.n_single), 16'd0);
    check_eq("rst_ndbl",  16'(bus_if.n_double), 16'd0);
    reset = 1'b0;

    check_eq("enc_7ff", secded_encode(11'h7FF), 16'hFFFF);

    // Clean words with stray starts at edges 3 and 40.
    load_run(0);
    do_run("clean", 1'b1, 4'd0, 4'd0);

    // Single flips at positions 0..14.
    load_run(1);
    do_run("single", 1'b0, 4'd15, 4'd0);

    // Restart straight from DONE: position-15 flip, one double error, clean rest.
    load_run(2);
    do_run("mixed", 1'b0, 4'd1, 4'd1);

    // Reset mid-run at edge 12: words 0,1 written, word 2 untouched.
    for (int i = 0; i < 2 * NW; i++) poke(DST + i, 8'hEE);
    base = wr_cnt;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_wen",  16'(bus_if.dm_wen), 16'd0);
    check_eq("mid_rst_done", 16'(bus_if.done), 16'd0);
    check_eq("mid_rst_busy", 16'(bus_if.busy), 16'd0);
    check_eq("mid_rst_nsgl", 16'(bus_if.n_single), 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_rst_writes", 16'(wr_cnt - base), 16'd4);
    check_eq("mid_rst_idle_done", 16'(bus_if.done), 16'd0);
    check_eq("mid_rst_word0", {mem[DST + 1], mem[DST]}, exp_w[0]);
    check_eq("mid_rst_word1", {mem[DST + 3], mem[DST + 2]}, exp_w[1]);
    check_eq("mid_rst_word2", {mem[DST + 5], mem[DST + 4]}, 16'hEEEE);
    do_run("restart", 1'b0, 4'd1, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
